// File: rtl/dot_seq_pkg.sv
// rtl/dot_seq_pkg.sv - shared states, DSP OPMODE codes and operand widths for dot_seq
package dot_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] OPM_IDLE  = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    localparam int OPND_W = 18;
    localparam int PROD_W = 36;
    localparam int ACC_W  = 48;

    // Tag {valid, first} -> OPMODE at the post-adder; upper nibble always zero.
    function automatic logic [7:0] opmode_of(input logic valid, input logic first);
        if (!valid) begin
            return OPM_IDLE;
        end
        return first ? OPM_FIRST : OPM_ACC;
    endfunction

endpackage

// File: rtl/dot_seq_tagpipe.sv
// rtl/dot_seq_tagpipe.sv - fixed-depth shift register carrying {valid, first} tags beside the DSP pipe
module dot_seq_tagpipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tag_in,
    output logic [WIDTH-1:0] tag_out
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/dot_seq.sv
// rtl/dot_seq.sv - dot-product operand sequencer driving an external DSP MAC slice; DOT_SEQ_OVF_EN enables R_OVF tracking
module dot_seq
    import dot_seq_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [17:0]       S_A,
    input  logic [17:0]       S_B,
    output logic              R_VALID,
    input  logic              R_READY,
    output logic [47:0]       R_DATA,
    output logic              R_OVF,
    output logic [17:0]       DSP_A,
    output logic [17:0]       DSP_B,
    output logic [7:0]        DSP_OPMODE,
    input  logic [47:0]       DSP_P,
    input  logic              DSP_CARRYOUT
);

    localparam int DRN_W = (DSP_LAT > 2) ? $clog2(DSP_LAT) : 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic               first_q, first_d;
    logic [ACC_W-1:0]   r_data_q, r_data_d;

    logic               accept;
    logic               start_job;
    logic [1:0]         tag_in;
    logic [1:0]         tag_out;

    assign accept    = (state_q == ST_RUN) && S_VALID;
    assign start_job = (state_q == ST_IDLE) && START;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        first_d  = first_q;
        r_data_d = r_data_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (LEN != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = LEN;
                        first_d = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        r_data_d = '0;
                    end
                end
            end
            ST_RUN: begin
                first_d = 1'b0;
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                        drn_d   = DRN_W'(DSP_LAT - 1);
                    end
                end
            end
            ST_DRAIN: begin
                // Last term reaches P DSP_LAT cycles after its accept.
                if (drn_q == '0) begin
                    r_data_d = DSP_P;
                    state_d  = ST_DONE;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            ST_DONE: begin
                if (R_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            drn_q    <= '0;
            first_q  <= 1'b0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drn_q    <= drn_d;
            first_q  <= first_d;
            r_data_q <= r_data_d;
        end
    end

    // Every RUN cycle, bubble or not, injects a tag so zero products still accumulate.
    assign tag_in = {state_q == ST_RUN, (state_q == ST_RUN) && first_q};

    dot_seq_tagpipe #(
        .DEPTH (DSP_LAT - 1),
        .WIDTH (2)
    ) u_tagpipe (
        .clk     (CLK),
        .rst     (RST),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign BUSY       = (state_q != ST_IDLE);
    assign S_READY    = (state_q == ST_RUN);
    assign R_VALID    = (state_q == ST_DONE);
    assign R_DATA     = r_data_q;
    assign DSP_A      = accept ? S_A : '0;
    assign DSP_B      = accept ? S_B : '0;
    assign DSP_OPMODE = opmode_of(tag_out[1], tag_out[0]);

`ifdef DOT_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic p_live_q, p_live_d;

    // P holds a tagged term exactly one cycle after a valid tag left the pipe.
    always_comb begin
        p_live_d = tag_out[1];
        ovf_d    = ovf_q;
        if (start_job) begin
            ovf_d = 1'b0;
        end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && p_live_q && DSP_CARRYOUT) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q    <= 1'b0;
            p_live_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            p_live_q <= p_live_d;
        end
    end

    assign R_OVF = ovf_q;
`else
    logic unused_ovf_inputs;
    assign unused_ovf_inputs = DSP_CARRYOUT ^ start_job;
    assign R_OVF             = 1'b0;
`endif

endmodule
